// File: rtl/eth_mac_tx_if.sv
// Host/FIFO/MII-side signal bundle for eth_mac_tx; the master drives frame requests and FIFO data,
// the slave (the MAC) drives the FIFO read strobe and the MII transmit pins.
interface eth_mac_tx_if #(parameter int DW = 4);
    logic          tx_go;
    logic [11:0]   data_len;
    logic [47:0]   des_mac;
    logic [47:0]   src_mac;
    logic [15:0]   len_type;
    logic          fifo_rq;
    logic [DW-1:0] fifo_da;
    logic [31:0]   crc_res;
    logic          crc_en;
    logic          mii_tx_en;
    logic          mii_tx_er;
    logic [DW-1:0] mii_tx_da;
    logic          tx_busy;
    logic          tx_done;

    modport master (
        output tx_go, data_len, des_mac, src_mac, len_type, fifo_da, crc_res,
        input  fifo_rq, crc_en, mii_tx_en, mii_tx_er, mii_tx_da, tx_busy, tx_done
    );

    modport slave (
        input  tx_go, data_len, des_mac, src_mac, len_type, fifo_da, crc_res,
        output fifo_rq, crc_en, mii_tx_en, mii_tx_er, mii_tx_da, tx_busy, tx_done
    );
endinterface

// File: rtl/eth_mac_tx.sv
// Ethernet MII/GMII transmit framer: preamble, SFD, DA, SA, L/T, payload, zero pad, FCS, IFG.
// Define ETH_MAC_TX_CRC_EN to generate the FCS internally instead of taking it from crc_res.
module eth_mac_tx #(
    parameter int DW          = 4,
    parameter int PRE_BYTES   = 7,
    parameter int IFG_BYTES   = 12,
    parameter int MIN_PAYLOAD = 46
) (
    input logic         mii_tx_clk,
    input logic         rst_n,
    eth_mac_tx_if.slave bus
);
    localparam int          SPB     = 8 / DW;
    localparam int          LSB     = (DW == 4) ? 1 : 0;
    localparam logic [11:0] MAX_LEN = 12'd1500;

    typedef enum logic [3:0] {IDLE, PRE, SFD, DA, SA, LT, DATA, PAD, FCS, IFG} state_t;

    state_t        state_q, state_d;
    logic          go_q, go_d;
    logic [11:0]   cnt_q, cnt_d, len_q, len_d, rem_q, rem_d;
    logic [11:0]   lim, len_clamp;
    logic [47:0]   sh_q, sh_d, src_q, src_d;
    logic [15:0]   lt_q, lt_d;
    logic [31:0]   fcs_val;
    logic [DW-1:0] sym;
    logic          last, hi, byte_end, tx_en, crc_on, rq, pad_need;

    function automatic logic [DW-1:0] sym_of(input logic [7:0] b, input logic h);
        logic [7:0] t;
        t = (DW == 8) ? b : (h ? {4'h0, b[7:4]} : {4'h0, b[3:0]});
        return t[DW-1:0];
    endfunction

    assign hi        = (DW == 4) ? cnt_q[0] : 1'b0;
    assign byte_end  = (DW == 4) ? cnt_q[0] : 1'b1;
    assign len_clamp = (bus.data_len > MAX_LEN) ? MAX_LEN : bus.data_len;
    assign pad_need  = (len_q < 12'(MIN_PAYLOAD));
    assign tx_en     = state_q inside {PRE, SFD, DA, SA, LT, DATA, PAD, FCS};
    assign crc_on    = state_q inside {DA, SA, LT, DATA, PAD};
    assign last      = (cnt_q == lim - 12'd1);

    always_comb begin
        case (state_q)
            PRE:     lim = 12'(PRE_BYTES * SPB);
            SFD:     lim = 12'(SPB);
            DA, SA:  lim = 12'(6 * SPB);
            LT:      lim = 12'(2 * SPB);
            DATA:    lim = len_q << LSB;
            PAD:     lim = 12'((MIN_PAYLOAD - int'(len_q)) * SPB);
            FCS:     lim = 12'(4 * SPB);
            IFG:     lim = 12'(IFG_BYTES * SPB);
            default: lim = 12'd1;
        endcase
    end

    always_comb begin
        case (state_q)
            PRE:             sym = sym_of(8'h55, hi);
            SFD:             sym = sym_of(8'hD5, hi);
            DA, SA, LT, FCS: sym = sym_of(sh_q[47:40], hi);
            DATA:            sym = bus.fifo_da;
            default:         sym = '0;
        endcase
    end

    // The read strobe leads DATA by one cycle so fifo_da lines up with each DATA symbol.
    assign rq            = (state_q == LT && last && len_q != 12'd0) || (state_q == DATA && !last);
    assign bus.fifo_rq   = rq;
    assign bus.crc_en    = crc_on;
    assign bus.mii_tx_en = tx_en;
    assign bus.mii_tx_da = tx_en ? sym : '0;
    assign bus.mii_tx_er = (state_q == DATA) && rq && (rem_q == 12'd0);
    assign bus.tx_busy   = go_q || (state_q != IDLE);
    assign bus.tx_done   = (state_q == IFG) && last;

`ifdef ETH_MAC_TX_CRC_EN
    logic [31:0] crc_q, crc_d, crc_nxt, crc_inv;

    always_comb begin
        crc_nxt = crc_q;
        for (int i = 0; i < DW; i++)
            crc_nxt = (crc_nxt[0] ^ sym[i]) ? ((crc_nxt >> 1) ^ 32'hEDB88320) : (crc_nxt >> 1);
        crc_inv = ~crc_nxt;
        // Byte-swapped so the shared MSB-byte-first shifter sends the register LSB-first.
        fcs_val = {crc_inv[7:0], crc_inv[15:8], crc_inv[23:16], crc_inv[31:24]};
        crc_d   = crc_on ? crc_nxt : 32'hFFFF_FFFF;
    end

    always_ff @(posedge mii_tx_clk or negedge rst_n)
        if (!rst_n) crc_q <= 32'hFFFF_FFFF;
        else        crc_q <= crc_d;
`else
    assign fcs_val = bus.crc_res;
`endif

    always_comb begin
        state_d = state_q;
        go_d    = go_q;
        cnt_d   = cnt_q;
        len_d   = len_q;
        rem_d   = rem_q;
        sh_d    = sh_q;
        src_d   = src_q;
        lt_d    = lt_q;
        if (rq && rem_q != 12'd0) rem_d = rem_q - 12'd1;
        if (state_q == IDLE) begin
            // One holding cycle puts the first preamble symbol two cycles after tx_go.
            if (go_q) begin
                go_d    = 1'b0;
                state_d = PRE;
                cnt_d   = '0;
            end else if (bus.tx_go) begin
                go_d  = 1'b1;
                len_d = len_clamp;
                rem_d = len_clamp << LSB;
                sh_d  = bus.des_mac;
                src_d = bus.src_mac;
                lt_d  = bus.len_type;
            end
        end else begin
            cnt_d = cnt_q + 12'd1;
            if (byte_end && state_q inside {DA, SA, LT, FCS}) sh_d = sh_q << 8;
            if (last) begin
                cnt_d = '0;
                case (state_q)
                    PRE: state_d = SFD;
                    SFD: state_d = DA;
                    DA:  begin state_d = SA; sh_d = src_q; end
                    SA:  begin state_d = LT; sh_d = {lt_q, 32'h0}; end
                    LT: begin
                        if (len_q != 12'd0)  state_d = DATA;
                        else if (pad_need)   state_d = PAD;
                        else begin state_d = FCS; sh_d = {fcs_val, 16'h0}; end
                    end
                    DATA: begin
                        if (pad_need) state_d = PAD;
                        else begin state_d = FCS; sh_d = {fcs_val, 16'h0}; end
                    end
                    PAD:     begin state_d = FCS; sh_d = {fcs_val, 16'h0}; end
                    FCS:     state_d = IFG;
                    default: state_d = IDLE;
                endcase
            end
        end
    end

    always_ff @(posedge mii_tx_clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            go_q    <= 1'b0;
            cnt_q   <= '0;
            len_q   <= '0;
            rem_q   <= '0;
            sh_q    <= '0;
            src_q   <= '0;
            lt_q    <= '0;
        end else begin
            state_q <= state_d;
            go_q    <= go_d;
            cnt_q   <= cnt_d;
            len_q   <= len_d;
            rem_q   <= rem_d;
            sh_q    <= sh_d;
            src_q   <= src_d;
            lt_q    <= lt_d;
        end
    end
endmodule

// File: tb/tb_eth_mac_tx.sv
// Self-checking bench for eth_mac_tx: MII (DW=4) and byte-wide (DW=8) instances, frame scoreboard.
module tb_eth_mac_tx;
    localparam logic [31:0] CRC_RES = 32'hA1B2_C3D4;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   errors = 0;
    int   checks = 0;
    int   rd4 = 0;
    int   base4 = 0;
    logic rq4_s = 1'b0;

    always #5 clk = ~clk;

    eth_mac_tx_if #(.DW(4)) b4 ();
    eth_mac_tx_if #(.DW(8)) b8 ();

    eth_mac_tx #(.DW(4)) dut4 (.mii_tx_clk(clk), .rst_n(rst_n), .bus(b4));
    eth_mac_tx #(.DW(8)) dut8 (.mii_tx_clk(clk), .rst_n(rst_n), .bus(b8));

    // FIFO model: a read request seen in cycle t presents the next payload nibble in cycle t+1.
    always @(negedge clk) rq4_s = b4.fifo_rq;
    always @(posedge clk) begin
        logic [7:0] pb;
        #1;
        if (rq4_s) begin
            pb = 8'((rd4 - base4) >> 1);
            b4.fifo_da = ((rd4 - base4) % 2 == 1) ? pb[7:4] : pb[3:0];
            rd4 = rd4 + 1;
        end
    end

    function automatic logic [31:0] crc_calc(input logic [7:0] d[$]);
        logic [31:0] c;
        c = 32'hFFFF_FFFF;
        foreach (d[i])
            for (int b = 0; b < 8; b++)
                c = (c[0] ^ d[i][b]) ? ((c >> 1) ^ 32'hEDB88320) : (c >> 1);
        return c;
    endfunction

    // Header + payload + pad bytes (the CRC span), then the four FCS bytes as transmitted.
    function automatic void build_bytes(input int le, input logic [47:0] da, input logic [47:0] sa,
                                        input logic [15:0] lt, input logic zero_pay,
                                        output logic [7:0] by[$]);
        logic [31:0] fb;
        logic [31:0] c;
        by = {};
        for (int i = 5; i >= 0; i--) by.push_back(da[i*8 +: 8]);
        for (int i = 5; i >= 0; i--) by.push_back(sa[i*8 +: 8]);
        by.push_back(lt[15:8]);
        by.push_back(lt[7:0]);
        for (int i = 0; i < le; i++) by.push_back(zero_pay ? 8'h00 : 8'(i));
        for (int i = le; i < 46; i++) by.push_back(8'h00);
        c = ~crc_calc(by);
`ifdef ETH_MAC_TX_CRC_EN
        fb = {c[7:0], c[15:8], c[23:16], c[31:24]};
`else
        fb = CRC_RES;
        c  = 32'h0;
`endif
        for (int i = 3; i >= 0; i--) by.push_back(fb[i*8 +: 8]);
    endfunction

    // Caller enters at a falling edge; tx_go is raised immediately.
    task automatic run4(input string tag, input int len, input logic [47:0] da, input logic [47:0] sa,
                        input logic [15:0] lt, input int go_at, input int exp_en, input int exp_rq);
        logic [3:0] q[$];
        logic [7:0] by[$];
        logic [3:0] e;
        int le, en_n, rq_n, done_n, ifg_n, er_n, da_bad, first, k;
        bit fin;
        le = (len > 1500) ? 1500 : len;
        en_n = 0; rq_n = 0; done_n = 0; ifg_n = 0; er_n = 0; da_bad = 0; first = -1; fin = 0;
        q = {};
        for (int i = 0; i < 7; i++) begin q.push_back(4'h5); q.push_back(4'h5); end
        q.push_back(4'h5);
        q.push_back(4'hD);
        build_bytes(le, da, sa, lt, 1'b0, by);
        foreach (by[i]) begin q.push_back(by[i][3:0]); q.push_back(by[i][7:4]); end

        base4 = rd4;
        b4.data_len = 12'(len);
        b4.des_mac  = da;
        b4.src_mac  = sa;
        b4.len_type = lt;
        b4.tx_go    = 1'b1;
        @(negedge clk);
        b4.tx_go = 1'b0;
        k = 1;
        while (!fin) begin
            if (b4.mii_tx_en) begin
                if (first < 0) first = k;
                en_n++;
                checks++;
                if (q.size() == 0) begin
                    errors++;
                    $display("FAIL %s sym%0d: got %h, expected no more symbols", tag, en_n, b4.mii_tx_da);
                end else begin
                    e = q.pop_front();
                    if (b4.mii_tx_da !== e) begin
                        errors++;
                        $display("FAIL %s sym%0d: got %h expected %h", tag, en_n, b4.mii_tx_da, e);
                    end
                end
            end else begin
                if (b4.tx_busy && first >= 0) ifg_n++;
                if (b4.mii_tx_da !== 4'h0) da_bad++;
            end
            if (b4.mii_tx_er) er_n++;
            if (b4.fifo_rq) rq_n++;
            if (b4.tx_done) done_n++;
            b4.tx_go = (go_at > 0 && b4.mii_tx_en && en_n == go_at);
            if (done_n > 0 && !b4.tx_busy) fin = 1;
            else if (k > 6000) begin
                fin = 1;
                errors++;
                $display("FAIL %s timeout: busy=%0d after %0d cycles", tag, b4.tx_busy, k);
            end else begin
                @(negedge clk);
                k++;
            end
        end
        b4.tx_go = 1'b0;
        checks++; if (first !== 2)        begin errors++; $display("FAIL %s latency: got %0d expected 2", tag, first); end
        checks++; if (en_n !== exp_en)    begin errors++; $display("FAIL %s en_cycles: got %0d expected %0d", tag, en_n, exp_en); end
        checks++; if (rq_n !== exp_rq)    begin errors++; $display("FAIL %s rq_cycles: got %0d expected %0d", tag, rq_n, exp_rq); end
        checks++; if (ifg_n !== 24)       begin errors++; $display("FAIL %s ifg_cycles: got %0d expected 24", tag, ifg_n); end
        checks++; if (done_n !== 1)       begin errors++; $display("FAIL %s done_pulses: got %0d expected 1", tag, done_n); end
        checks++; if (er_n !== 0)         begin errors++; $display("FAIL %s tx_er: got %0d expected 0", tag, er_n); end
        checks++; if (da_bad !== 0)       begin errors++; $display("FAIL %s idle_data: got %0d nonzero expected 0", tag, da_bad); end
        checks++; if (q.size() !== 0)     begin errors++; $display("FAIL %s missing_syms: got %0d left expected 0", tag, q.size()); end
        checks++; if (rd4 - base4 !== exp_rq) begin errors++; $display("FAIL %s fifo_reads: got %0d expected %0d", tag, rd4 - base4, exp_rq); end
    endtask

    task automatic test_reset();
        #12;
        @(negedge clk);
        checks++; if (b4.mii_tx_en !== 1'b0) begin errors++; $display("FAIL rst_en: got %b expected 0", b4.mii_tx_en); end
        checks++; if (b4.mii_tx_er !== 1'b0) begin errors++; $display("FAIL rst_er: got %b expected 0", b4.mii_tx_er); end
        checks++; if (b4.mii_tx_da !== 4'h0) begin errors++; $display("FAIL rst_da: got %h expected 0", b4.mii_tx_da); end
        checks++; if (b4.fifo_rq !== 1'b0)   begin errors++; $display("FAIL rst_rq: got %b expected 0", b4.fifo_rq); end
        checks++; if (b4.crc_en !== 1'b0)    begin errors++; $display("FAIL rst_crc_en: got %b expected 0", b4.crc_en); end
        checks++; if (b4.tx_busy !== 1'b0)   begin errors++; $display("FAIL rst_busy: got %b expected 0", b4.tx_busy); end
        checks++; if (b4.tx_done !== 1'b0)   begin errors++; $display("FAIL rst_done: got %b expected 0", b4.tx_done); end
        checks++; if (b8.mii_tx_en !== 1'b0) begin errors++; $display("FAIL rst_en8: got %b expected 0", b8.mii_tx_en); end
        rst_n = 1'b1;
    endtask

    task automatic test_dw8_zero_len();
        logic [7:0] q[$];
        logic [7:0] by[$];
        logic [7:0] e;
        int en_n, rq_n, first, k;
        en_n = 0; rq_n = 0; first = -1;
        q = {};
        for (int i = 0; i < 7; i++) q.push_back(8'h55);
        q.push_back(8'hD5);
        build_bytes(0, 48'h0011_2233_4455, 48'h0A0B_0C0D_0E0F, 16'h002E, 1'b1, by);
        foreach (by[i]) q.push_back(by[i]);
        @(negedge clk);
        b8.data_len = 12'd0;
        b8.des_mac  = 48'h0011_2233_4455;
        b8.src_mac  = 48'h0A0B_0C0D_0E0F;
        b8.len_type = 16'h002E;
        b8.tx_go    = 1'b1;
        @(negedge clk);
        b8.tx_go = 1'b0;
        for (k = 1; k < 300 && !(k > 2 && !b8.tx_busy); k++) begin
            if (b8.mii_tx_en) begin
                if (first < 0) first = k;
                en_n++;
                e = (q.size() > 0) ? q.pop_front() : 8'hXX;
                checks++;
                if (b8.mii_tx_da !== e) begin errors++; $display("FAIL dw8 byte%0d: got %h expected %h", en_n, b8.mii_tx_da, e); end
            end
            if (b8.fifo_rq) rq_n++;
            @(negedge clk);
        end
        checks++; if (first !== 2) begin errors++; $display("FAIL dw8 latency: got %0d expected 2", first); end
        checks++; if (en_n !== 72) begin errors++; $display("FAIL dw8 en_cycles: got %0d expected 72", en_n); end
        checks++; if (rq_n !== 0)  begin errors++; $display("FAIL dw8 rq_cycles: got %0d expected 0", rq_n); end
        checks++; if (b8.tx_busy !== 1'b0) begin errors++; $display("FAIL dw8 busy_end: got %b expected 0", b8.tx_busy); end
    endtask

    task automatic test_back_to_back();
        int stray;
        stray = 0;
        @(negedge clk);
        run4("go_in_fcs", 46, 48'h0200_0000_0007, 48'h0200_0000_0008, 16'h0800, 140, 144, 92);
        repeat (40) begin
            @(negedge clk);
            if (b4.mii_tx_en || b4.tx_busy) stray++;
        end
        checks++; if (stray !== 0) begin errors++; $display("FAIL second_frame: got %0d active cycles expected 0", stray); end
    endtask

    task automatic test_reset_abort();
        int en_n;
        en_n = 0;
        @(negedge clk);
        b4.data_len = 12'd46;
        b4.des_mac  = 48'h1111_2222_3333;
        b4.src_mac  = 48'h4444_5555_6666;
        b4.len_type = 16'h0800;
        b4.tx_go    = 1'b1;
        @(negedge clk);
        b4.tx_go = 1'b0;
        for (int k = 0; k < 200 && en_n < 30; k++) begin
            if (b4.mii_tx_en) en_n++;
            if (en_n < 30) @(negedge clk);
        end
        rst_n = 1'b0;
        #1;
        checks++; if (en_n !== 30) begin errors++; $display("FAIL abort_reach: got %0d en cycles expected 30", en_n); end
        checks++; if (b4.mii_tx_en !== 1'b0 || b4.tx_busy !== 1'b0 || b4.mii_tx_da !== 4'h0)
            begin errors++; $display("FAIL abort_outputs: got en=%b busy=%b da=%h expected all 0", b4.mii_tx_en, b4.tx_busy, b4.mii_tx_da); end
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        run4("after_reset", 46, 48'h1111_2222_3333, 48'h4444_5555_6666, 16'h0800, 0, 144, 92);
    endtask

    initial begin
        b4.tx_go = 1'b0; b4.data_len = '0; b4.des_mac = '0; b4.src_mac = '0; b4.len_type = '0;
        b4.fifo_da = '0; b4.crc_res = CRC_RES;
        b8.tx_go = 1'b0; b8.data_len = '0; b8.des_mac = '0; b8.src_mac = '0; b8.len_type = '0;
        b8.fifo_da = '0; b8.crc_res = CRC_RES;

        test_reset();
        // REQ-031-style start: tx_go on the very first edge after release is covered in test_reset_abort.
        test_dw8_zero_len();
        @(negedge clk);
        run4("min_frame", 46, 48'hFFFF_FFFF_FFFF, 48'h0200_0000_0001, 16'h0800, 0, 144, 92);
        @(negedge clk);
        run4("short_pad", 10, 48'h0123_4567_89AB, 48'hCDEF_0011_2233, 16'h000A, 0, 144, 20);
        @(negedge clk);
        run4("zero_len", 0, 48'hA5A5_5A5A_F00F, 48'h0F0F_F0F0_1234, 16'h0000, 0, 144, 0);
        @(negedge clk);
        run4("no_pad", 60, 48'h0102_0304_0506, 48'h0708_090A_0B0C, 16'h86DD, 0, 172, 120);
        @(negedge clk);
        run4("clamp", 1600, 48'h0002_0004_0006, 48'h0008_000A_000C, 16'h0640, 0, 3052, 3000);
        test_back_to_back();
        test_reset_abort();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/eth_mac_tx.md
ETH_MAC_TX -- requirements
Module: eth_mac_tx

Interface
REQ-001 SHALL provide parameter DW, default 4, meaning data path width in bits: 4 for MII, 8 for GMII-style byte path.
REQ-002 SHALL provide parameter PRE_BYTES, default 7, meaning preamble bytes (0x55) before SFD; legal range 1..7.
REQ-003 SHALL provide parameter IFG_BYTES, default 12, meaning inter-frame gap in byte times; legal range 1..31.
REQ-004 SHALL provide parameter MIN_PAYLOAD, default 46, meaning minimum payload bytes after padding.
REQ-005 mii_tx_clk  in  1  sole clock; all logic rising-edge.
REQ-006 rst_n  in  1  asynchronous, active-low reset.
REQ-007 tx_go  in  1  single-cycle frame start request.
REQ-008 data_len  in  12  payload bytes held in the external FIFO.
REQ-009 des_mac / src_mac  in  48 each  destination and source address.
REQ-010 len_type  in  16  Length/Type field.
REQ-011 fifo_rq  out  1  FIFO read request; fifo_da valid the cycle after.
REQ-012 fifo_da  in  DW  payload data from FIFO.
REQ-013 crc_res  in  32  external CRC value; used only without the CRC macro.
REQ-014 crc_en  out  1  high while the DA..pad fields are being driven.
REQ-015 mii_tx_en / mii_tx_er  out  1 each  transmit enable / error.
REQ-016 mii_tx_da  out  DW  transmit data.
REQ-017 tx_busy  out  1  high from accepted tx_go until IFG ends; tx_done  out  1  one-cycle pulse at IFG end.

Function
REQ-018 FSM states SHALL be IDLE, PRE, SFD, DA, SA, LT, DATA, PAD, FCS, IFG, sequenced in that order; DATA skipped when data_len=0; PAD skipped when data_len>=MIN_PAYLOAD.
REQ-019 tx_go SHALL be accepted only in IDLE; it latches data_len, des_mac, src_mac and len_type; tx_go while tx_busy is ignored.
REQ-020 First preamble symbol SHALL appear on mii_tx_da, with mii_tx_en=1, exactly 2 cycles after the cycle tx_go is sampled high.
REQ-021 Each state SHALL last (field bytes)*8/DW cycles; bytes go out MSB-byte-first for DA, SA and LT; for DW=4, low nibble first within each byte.
REQ-022 SFD byte SHALL be 0xD5 (DW=4: 0x5, then 0xD).
REQ-023 fifo_rq SHALL be high for exactly data_len*8/DW cycles, starting one cycle before the DATA state.
REQ-024 data_len > 1500 SHALL be clamped to 1500; the excess FIFO content is left unread.
REQ-025 PAD SHALL emit zero bytes until the payload totals MIN_PAYLOAD bytes.
REQ-026 mii_tx_en SHALL be high from the first PRE symbol through the last FCS symbol, and low in IFG and IDLE.
REQ-027 mii_tx_da SHALL be 0 whenever mii_tx_en=0.
REQ-028 IFG SHALL last IFG_BYTES*8/DW cycles; tx_done pulses in its final cycle; tx_busy drops the following cycle.
REQ-029 mii_tx_er SHALL pulse high for one cycle during DATA if fifo_rq is high in DATA with zero payload bytes remaining (internal underflow guard); otherwise it is 0.

Reset
REQ-030 While rst_n=0, all outputs SHALL be 0 and the FSM SHALL be IDLE; assertion mid-frame aborts the frame immediately without emitting FCS.
REQ-031 After rst_n deasserts, the block SHALL accept tx_go on the first clock edge.

Configuration
REQ-032 With ETH_MAC_TX_CRC_EN defined, the block SHALL compute IEEE 802.3 CRC-32 internally (reflected, init 0xFFFFFFFF) over DA..pad, transmit the complemented register LSB-first, and ignore crc_res.
REQ-033 Without ETH_MAC_TX_CRC_EN, FCS SHALL transmit crc_res sampled on the last crc_en cycle, in byte order [31:24], [23:16], [15:8], [7:0], low nibble first when DW=4.

Verification
REQ-034 DW=4, data_len=46, tx_go -> mii_tx_en high for 144 cycles; IFG 24 cycles; one tx_done pulse; fifo_rq high for 92 cycles.
REQ-035 DW=4, data_len=10 -> fifo_rq high for 20 cycles; 36 zero pad bytes; mii_tx_en still high for 144 cycles.
REQ-036 ETH_MAC_TX_CRC_EN defined, DA=FF:FF:FF:FF:FF:FF, len_type=0x0800, payload 46 bytes 0x00..0x2D -> CRC-32 over DA..FCS yields residue 0xC704DD7B.
REQ-037 DW=8, PRE_BYTES=7, data_len=0 -> 72 enable cycles, 46 zero pad bytes, fifo_rq never high.
REQ-038 rst_n pulled low at the 30th enable cycle -> mii_tx_en=0 and tx_busy=0 immediately; a new tx_go after release yields a complete frame.
REQ-039 Second tx_go issued during FCS -> ignored; no second frame is sent until a tx_go arrives after tx_done.
